// File: rtl/bram_arb_pkg.sv
// -----------------------------------------------------------------------------
// bram_arb_pkg
//   Shared definitions for the two-port block-RAM arbiter: port count, default
//   RAM geometry, the port identifier enum and a request record at the default
//   geometry (handy for requester models and benches).
// -----------------------------------------------------------------------------
package bram_arb_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  typedef enum logic {
    PORT0 = 1'b0,  // instruction fetch
    PORT1 = 1'b1   // load/store
  } port_id_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic                  we;
    logic [BE_W_DEF-1:0]   be;
    logic [DATA_W_DEF-1:0] wdata;
  } bram_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin arbiter. Grants combinationally among the eligible
//   requests; when both are eligible the port not granted most recently wins.
//   The last-grant flop moves only when a grant is actually issued.
//
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (forces grant to zero)
//   i_req      in   eligible request vector, bit i = port i
//   i_advance  in   a grant is being taken this cycle
//   o_grant    out  one-hot grant (all zero when nothing eligible)
// -----------------------------------------------------------------------------
module rr_arbiter2
  import bram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_advance,
  output logic [NUM_PORTS-1:0] o_grant
);

  port_id_t r_last_grant;

  // Reset to PORT1 so that port 0 wins the first contended round.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= PORT1;
    end else if (i_advance) begin
      r_last_grant <= o_grant[1] ? PORT1 : PORT0;
    end
  end

  // NOTE: o_grant is given a default before any branch; without it a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    o_grant = '0;
    if (!rst) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = (r_last_grant == PORT0) ? 2'b10 : 2'b01;
        default: o_grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
//   Shares one single-port, one-cycle-latency block RAM between the fetch
//   port (0) and the load/store port (1). Requests are granted round-robin,
//   RAM controls are driven straight from the winner, read data is captured
//   into a per-port response register and held until the requester takes it.
//
//   CLOCK_50                 in   clock, rising edge
//   rst                      in   synchronous active-high reset
//   reqN_valid/ready         in/out request handshake (ready = grant)
//   reqN_addr/we/be/wdata    in   request payload, held until ready
//   rspN_valid/rdata         out  read response, held until rspN_ready
//   rspN_ready               in   requester accepts response
//   ram_addr/we/be/wdata     out  RAM control, valid in the grant cycle
//   ram_rdata                in   RAM data, valid the cycle after the address
// -----------------------------------------------------------------------------
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic                  req0_we,
  input  logic [DATA_W/8-1:0]   req0_be,
  input  logic [DATA_W-1:0]     req0_wdata,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic                  req1_we,
  input  logic [DATA_W/8-1:0]   req1_be,
  input  logic [DATA_W-1:0]     req1_wdata,

  output logic                  rsp0_valid,
  output logic [DATA_W-1:0]     rsp0_rdata,
  input  logic                  rsp0_ready,

  output logic                  rsp1_valid,
  output logic [DATA_W-1:0]     rsp1_rdata,
  input  logic                  rsp1_ready,

  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [DATA_W/8-1:0]   ram_be,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int BE_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t                 w_req [NUM_PORTS];
  req_t                 w_win;
  logic [NUM_PORTS-1:0] w_req_valid;
  logic [NUM_PORTS-1:0] w_rsp_ready;
  logic [NUM_PORTS-1:0] w_inflight;
  logic [NUM_PORTS-1:0] w_rsp_valid;
  logic [NUM_PORTS-1:0] w_elig;
  logic [NUM_PORTS-1:0] w_grant;
  logic                 w_any_grant;
  logic [DATA_W-1:0]    w_rsp_rdata [NUM_PORTS];

  logic [ADDR_W-1:0]    r_hold_addr;
  logic [DATA_W-1:0]    r_hold_wdata;

  assign w_req[0] = '{addr: req0_addr, we: req0_we, be: req0_be, wdata: req0_wdata};
  assign w_req[1] = '{addr: req1_addr, we: req1_we, be: req1_be, wdata: req1_wdata};

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  // Writes never produce a response, so they are always eligible. A read
  // needs a free response slot: nothing in flight, and the held response
  // either absent or being drained this very cycle.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_elig[i] = w_req_valid[i] &&
                  (w_req[i].we ||
                   (!w_inflight[i] && (!w_rsp_valid[i] || w_rsp_ready[i])));
    end
  end

  rr_arbiter2 u_rr (
    .clk       (CLOCK_50),
    .rst       (rst),
    .i_req     (w_elig),
    .i_advance (w_any_grant),
    .o_grant   (w_grant)
  );

  assign w_any_grant = |w_grant;
  assign w_win       = w_grant[1] ? w_req[1] : w_req[0];

  assign req0_ready  = w_grant[0];
  assign req1_ready  = w_grant[1];

  // Address and write data hold the last granted values on idle cycles so the
  // RAM inputs do not toggle when nothing is being accessed.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
    end else if (w_any_grant) begin
      r_hold_addr  <= w_win.addr;
      r_hold_wdata <= w_win.wdata;
    end
  end

  always_comb begin
    ram_addr  = r_hold_addr;
    ram_wdata = r_hold_wdata;
    ram_we    = 1'b0;
    ram_be    = '0;
    if (rst) begin
      ram_addr  = '0;
      ram_wdata = '0;
    end else if (w_any_grant) begin
      ram_addr  = w_win.addr;
      ram_wdata = w_win.wdata;
      ram_we    = w_win.we;
      ram_be    = w_win.we ? w_win.be : '0;
    end
  end

  // One response slot per port. A read granted at T is in flight during T+1;
  // the RAM data present in T+1 is captured at its closing edge, so the
  // response is visible from T+2. Only one read can be in flight overall
  // because at most one grant happens per cycle.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
    logic              r_inflight;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

    always_ff @(posedge CLOCK_50) begin
      if (rst) begin
        r_inflight  <= 1'b0;
        r_rsp_valid <= 1'b0;
        r_rsp_rdata <= '0;
      end else begin
        r_inflight <= w_grant[gi] && !w_req[gi].we;
        if (r_inflight) begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= ram_rdata;
        end else if (w_rsp_ready[gi]) begin
          r_rsp_valid <= 1'b0;
        end
      end
    end

    assign w_inflight[gi]  = r_inflight;
    assign w_rsp_valid[gi] = r_rsp_valid;
    assign w_rsp_rdata[gi] = r_rsp_rdata;
  end

  assign rsp0_valid = w_rsp_valid[0];
  assign rsp1_valid = w_rsp_valid[1];
  assign rsp0_rdata = w_rsp_rdata[0];
  assign rsp1_rdata = w_rsp_rdata[1];

endmodule

// File: tb/tb_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_arbiter
//   Directed vector table plus hand-written sequences and a randomised run
//   against a reference memory model for bram_arbiter. Inputs change 1 ns
//   after the rising edge; outputs are sampled 4 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_bram_arbiter;
  import bram_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          v    [2];
  logic          we   [2];
  logic [AW-1:0] a    [2];
  logic [BW-1:0] be   [2];
  logic [DW-1:0] wd   [2];
  logic          rr   [2];
  logic          rdy  [2];
  logic          rv   [2];
  logic [DW-1:0] rd   [2];
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int n_vec = 0;
  int n_bad = 0;

  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLOCK_50   (clk),
    .rst        (rst),
    .req0_valid (v[0]),  .req0_ready (rdy[0]), .req0_addr (a[0]),
    .req0_we    (we[0]), .req0_be    (be[0]),  .req0_wdata(wd[0]),
    .req1_valid (v[1]),  .req1_ready (rdy[1]), .req1_addr (a[1]),
    .req1_we    (we[1]), .req1_be    (be[1]),  .req1_wdata(wd[1]),
    .rsp0_valid (rv[0]), .rsp0_rdata (rd[0]),  .rsp0_ready(rr[0]),
    .rsp1_valid (rv[1]), .rsp1_rdata (rd[1]),  .rsp1_ready(rr[1]),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_be     (ram_be),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Block RAM model: byte-enabled write, registered read. The image is
  // reloaded while rst is high: mem[a] = a*3 with two special words.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= DW'(i * 3);
      mem[12'h005] <= 32'hA5A5A5A5;
      mem[12'h020] <= 32'h11111111;
    end else if (ram_we) begin
      for (int b = 0; b < BW; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; we[p] = 1'b0; a[p] = '0; be[p] = '0; wd[p] = '0; rr[p] = 1'b1;
    end
  endtask

  typedef struct {
    logic          v0, we0;  logic [AW-1:0] a0; logic [DW-1:0] wd0; logic [BW-1:0] be0;
    logic          v1, we1;  logic [AW-1:0] a1; logic [DW-1:0] wd1; logic [BW-1:0] be1;
    logic          rr0, rr1;
    logic          e_rdy0, e_rdy1, e_we;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic          e_rv0;    logic [DW-1:0] e_rd0;
    logic          e_rv1;    logic [DW-1:0] e_rd1;
  } vec_t;

  function automatic vec_t mk(
    logic v0, logic we0, logic [AW-1:0] a0, logic [DW-1:0] wd0, logic [BW-1:0] be0,
    logic v1, logic we1, logic [AW-1:0] a1, logic [DW-1:0] wd1, logic [BW-1:0] be1,
    logic e_rdy0, logic e_rdy1, logic e_we, logic [AW-1:0] e_addr, logic [BW-1:0] e_be,
    logic e_rv0, logic [DW-1:0] e_rd0, logic e_rv1, logic [DW-1:0] e_rd1);
    vec_t t;
    t.v0 = v0; t.we0 = we0; t.a0 = a0; t.wd0 = wd0; t.be0 = be0;
    t.v1 = v1; t.we1 = we1; t.a1 = a1; t.wd1 = wd1; t.be1 = be1;
    t.rr0 = 1'b1; t.rr1 = 1'b1;
    t.e_rdy0 = e_rdy0; t.e_rdy1 = e_rdy1; t.e_we = e_we; t.e_addr = e_addr; t.e_be = e_be;
    t.e_rv0 = e_rv0; t.e_rd0 = e_rd0; t.e_rv1 = e_rv1; t.e_rd1 = e_rd1;
    return t;
  endfunction

  vec_t tbl [17];

  // Random-phase state
  bram_req_t     cur [2];
  logic          pend [2];
  int            wait_cnt [2];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];

  initial begin
    // Contention, write-then-read, write/read collision.
    //            v we addr   wdata         be     v we addr   wdata         be     rdy0 rdy1 we addr  be     rv0 rd0            rv1 rd1
    tbl[0]  = mk(1,0,12'h010,32'h0,        4'h0,  1,0,12'h030,32'h0,        4'h0,  1,0,0,12'h010,4'h0, 0,32'h0,        0,32'h0);
    tbl[1]  = mk(1,0,12'h011,32'h0,        4'h0,  1,0,12'h030,32'h0,        4'h0,  0,1,0,12'h030,4'h0, 0,32'h0,        0,32'h0);
    tbl[2]  = mk(1,0,12'h011,32'h0,        4'h0,  1,0,12'h031,32'h0,        4'h0,  1,0,0,12'h011,4'h0, 1,32'h30,       0,32'h0);
    tbl[3]  = mk(1,0,12'h012,32'h0,        4'h0,  1,0,12'h031,32'h0,        4'h0,  0,1,0,12'h031,4'h0, 0,32'h0,        1,32'h90);
    tbl[4]  = mk(1,0,12'h012,32'h0,        4'h0,  1,0,12'h032,32'h0,        4'h0,  1,0,0,12'h012,4'h0, 1,32'h33,       0,32'h0);
    tbl[5]  = mk(0,0,12'h000,32'h0,        4'h0,  1,0,12'h032,32'h0,        4'h0,  0,1,0,12'h032,4'h0, 0,32'h0,        1,32'h93);
    tbl[6]  = mk(0,0,12'h000,32'h0,        4'h0,  0,0,12'h000,32'h0,        4'h0,  0,0,0,12'h032,4'h0, 1,32'h36,       0,32'h0);
    tbl[7]  = mk(0,0,12'h000,32'h0,        4'h0,  0,0,12'h000,32'h0,        4'h0,  0,0,0,12'h032,4'h0, 0,32'h0,        1,32'h96);
    tbl[8]  = mk(0,0,12'h000,32'h0,        4'h0,  1,1,12'h020,32'hDEADBEEF, 4'h3,  0,1,1,12'h020,4'h3, 0,32'h0,        0,32'h0);
    tbl[9]  = mk(1,0,12'h020,32'h0,        4'h0,  0,0,12'h000,32'h0,        4'h0,  1,0,0,12'h020,4'h0, 0,32'h0,        0,32'h0);
    tbl[10] = mk(0,0,12'h000,32'h0,        4'h0,  0,0,12'h000,32'h0,        4'h0,  0,0,0,12'h020,4'h0, 0,32'h0,        0,32'h0);
    tbl[11] = mk(0,0,12'h000,32'h0,        4'h0,  0,0,12'h000,32'h0,        4'h0,  0,0,0,12'h020,4'h0, 1,32'h1111BEEF, 0,32'h0);
    tbl[12] = mk(1,1,12'h040,32'h12345678, 4'hF,  1,0,12'h040,32'h0,        4'h0,  0,1,0,12'h040,4'h0, 0,32'h0,        0,32'h0);
    tbl[13] = mk(1,1,12'h040,32'h12345678, 4'hF,  1,0,12'h040,32'h0,        4'h0,  1,0,1,12'h040,4'hF, 0,32'h0,        0,32'h0);
    tbl[14] = mk(0,0,12'h000,32'h0,        4'h0,  1,0,12'h040,32'h0,        4'h0,  0,1,0,12'h040,4'h0, 0,32'h0,        1,32'hC0);
    tbl[15] = mk(0,0,12'h000,32'h0,        4'h0,  0,0,12'h000,32'h0,        4'h0,  0,0,0,12'h040,4'h0, 0,32'h0,        0,32'h0);
    tbl[16] = mk(0,0,12'h000,32'h0,        4'h0,  0,0,12'h000,32'h0,        4'h0,  0,0,0,12'h040,4'h0, 0,32'h0,        1,32'h12345678);

    // ---------------- reset state, requests present during reset
    rst = 1'b1;
    set_idle();
    next_cycle();
    v[0] = 1'b1; a[0] = 12'h010;
    v[1] = 1'b1; we[1] = 1'b1; a[1] = 12'h055; be[1] = 4'hF; wd[1] = 32'hCAFEF00D;
    for (int k = 0; k < 2; k++) begin
      #3;
      check("rst rdy0",      rdy[0],    0);
      check("rst rdy1",      rdy[1],    0);
      check("rst ram_we",    ram_we,    0);
      check("rst ram_be",    ram_be,    0);
      check("rst ram_addr",  ram_addr,  0);
      check("rst ram_wdata", ram_wdata, 0);
      check("rst rsp0_valid", rv[0],    0);
      check("rst rsp1_valid", rv[1],    0);
      next_cycle();
    end

    // ---------------- vector table
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i != 0) next_cycle();
      v[0] = tbl[i].v0; we[0] = tbl[i].we0; a[0] = tbl[i].a0; wd[0] = tbl[i].wd0; be[0] = tbl[i].be0;
      v[1] = tbl[i].v1; we[1] = tbl[i].we1; a[1] = tbl[i].a1; wd[1] = tbl[i].wd1; be[1] = tbl[i].be1;
      rr[0] = tbl[i].rr0; rr[1] = tbl[i].rr1;
      #3;
      check($sformatf("row%0d rdy0", i),     rdy[0],   tbl[i].e_rdy0);
      check($sformatf("row%0d rdy1", i),     rdy[1],   tbl[i].e_rdy1);
      check($sformatf("row%0d ram_we", i),   ram_we,   tbl[i].e_we);
      check($sformatf("row%0d ram_addr", i), ram_addr, tbl[i].e_addr);
      check($sformatf("row%0d ram_be", i),   ram_be,   tbl[i].e_be);
      check($sformatf("row%0d rsp0_valid", i), rv[0],  tbl[i].e_rv0);
      check($sformatf("row%0d rsp1_valid", i), rv[1],  tbl[i].e_rv1);
      if (tbl[i].e_rv0) check($sformatf("row%0d rsp0_rdata", i), rd[0], tbl[i].e_rd0);
      if (tbl[i].e_rv1) check($sformatf("row%0d rsp1_rdata", i), rd[1], tbl[i].e_rd1);
    end

    // ---------------- reset in the middle of a read
    next_cycle(); set_idle();
    v[0] = 1'b1; a[0] = 12'h010;
    #3 check("rstmid grant0", rdy[0], 1);
    next_cycle(); set_idle();
    rst = 1'b1;
    v[1] = 1'b1; we[1] = 1'b1; a[1] = 12'h055; be[1] = 4'hF; wd[1] = 32'h0BADF00D;
    #3;
    check("rstmid rdy0",     rdy[0],    0);
    check("rstmid rdy1",     rdy[1],    0);
    check("rstmid ram_we",   ram_we,    0);
    check("rstmid ram_be",   ram_be,    0);
    check("rstmid ram_addr", ram_addr,  0);
    check("rstmid ram_wdata", ram_wdata, 0);
    next_cycle();
    #3 check("rstmid rsp0 T+2", rv[0], 0);
    next_cycle(); rst = 1'b0; set_idle();
    #3 check("rstmid rsp0 T+3", rv[0], 0);
    next_cycle();
    v[0] = 1'b1; a[0] = 12'h011; v[1] = 1'b1; a[1] = 12'h031;
    #3;
    check("rstmid first rdy0", rdy[0], 1);
    check("rstmid first rdy1", rdy[1], 0);
    for (int k = 0; k < 3; k++) begin next_cycle(); set_idle(); end

    // ---------------- response backpressure on port 0
    next_cycle(); set_idle();
    v[0] = 1'b1; a[0] = 12'h005; rr[0] = 1'b0;
    #3 check("bp grant0", rdy[0], 1);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      v[0] = 1'b1; a[0] = 12'h006; rr[0] = 1'b0;
      v[1] = 1'b1; a[1] = 12'h030; rr[1] = 1'b1;
      #3;
      check($sformatf("bp%0d rdy0", k), rdy[0], 0);
      check($sformatf("bp%0d rdy1", k), rdy[1], (k % 2 == 1) ? 1 : 0);
      if (k >= 2) begin
        check($sformatf("bp%0d rsp0_valid", k), rv[0], 1);
        check($sformatf("bp%0d rsp0_rdata", k), rd[0], 32'hA5A5A5A5);
      end
    end
    next_cycle();
    v[1] = 1'b0; rr[0] = 1'b1;
    #3;
    check("bp release rsp0_valid", rv[0],  1);
    check("bp release rsp0_rdata", rd[0],  32'hA5A5A5A5);
    check("bp release rdy0",       rdy[0], 1);
    next_cycle(); set_idle();
    #3 check("bp drained rsp0_valid", rv[0], 0);
    next_cycle();
    #3;
    check("bp next rsp0_valid", rv[0], 1);
    check("bp next rsp0_rdata", rd[0], 32'h12);

    // ---------------- single requester: back-to-back writes on port 1
    for (int k = 0; k < 4; k++) begin
      next_cycle(); set_idle();
      v[1] = 1'b1; we[1] = 1'b1; a[1] = AW'(12'h100 + k); be[1] = 4'hF; wd[1] = 32'hC0DE0000 + k;
      #3;
      check($sformatf("wr%0d rdy1", k),      rdy[1],    1);
      check($sformatf("wr%0d rdy0", k),      rdy[0],    0);
      check($sformatf("wr%0d ram_we", k),    ram_we,    1);
      check($sformatf("wr%0d ram_addr", k),  ram_addr,  12'h100 + k);
      check($sformatf("wr%0d ram_wdata", k), ram_wdata, 32'hC0DE0000 + k);
      check($sformatf("wr%0d rsp1_valid", k), rv[1],    0);
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle(); set_idle();
      #3;
      check($sformatf("wridle%0d rsp1_valid", k), rv[1],    0);
      check($sformatf("wridle%0d ram_we", k),     ram_we,   0);
      check($sformatf("wridle%0d ram_be", k),     ram_be,   0);
      check($sformatf("wridle%0d ram_addr", k),   ram_addr, 12'h103);
      check($sformatf("wridle%0d ram_wdata", k),  ram_wdata, 32'hC0DE0003);
    end

    // ---------------- random traffic against a reference memory
    for (int i = 0; i < 16; i++) ref_mem[i] = DW'((12'h200 + i) * 3);
    for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; wait_cnt[p] = 0; cur[p] = '0; end
    for (int c = 0; c < 10000; c++) begin
      next_cycle();
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 9) < 7) begin
          pend[p]       = 1'b1;
          cur[p].addr   = AW'(12'h200 + $urandom_range(0, 15));
          cur[p].we     = ($urandom_range(0, 2) == 0);
          cur[p].be     = BW'($urandom_range(0, 15));
          cur[p].wdata  = $urandom;
        end
        v[p] = pend[p]; we[p] = cur[p].we; a[p] = cur[p].addr;
        be[p] = cur[p].be; wd[p] = cur[p].wdata;
        rr[p] = ($urandom_range(0, 3) != 0);
      end
      #3;
      // responses taken this cycle
      for (int p = 0; p < 2; p++) begin
        if (rv[p] && rr[p]) begin
          if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            n_vec++; n_bad++;
            $display("FAIL rnd rsp%0d unexpected: got %h, expected no response", p, rd[p]);
          end else if (p == 0) begin
            check("rnd rsp0_rdata", rd[0], exp_q0.pop_front());
          end else begin
            check("rnd rsp1_rdata", rd[1], exp_q1.pop_front());
          end
        end
      end
      check("rnd single grant", rdy[0] & rdy[1], 0);
      if ((v[0] && we[0]) || (v[1] && we[1])) check("rnd write progress", rdy[0] | rdy[1], 1);
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && cur[p].we && !rdy[p] && rdy[1-p]) begin
          wait_cnt[p]++;
          check($sformatf("rnd starve%0d", p), (wait_cnt[p] <= 1) ? 1 : 0, 1);
        end
      end
      // grants consumed at the coming edge, applied to the model in order
      for (int p = 0; p < 2; p++) begin
        if (rdy[p]) begin
          check($sformatf("rnd rdy%0d needs valid", p), v[p], 1);
          if (cur[p].we) begin
            for (int b = 0; b < BW; b++)
              if (cur[p].be[b]) ref_mem[cur[p].addr[3:0]][8*b +: 8] = cur[p].wdata[8*b +: 8];
          end else if (p == 0) begin
            exp_q0.push_back(ref_mem[cur[p].addr[3:0]]);
          end else begin
            exp_q1.push_back(ref_mem[cur[p].addr[3:0]]);
          end
          pend[p] = 1'b0;
          wait_cnt[p] = 0;
        end
      end
    end
    // drain outstanding responses
    for (int c = 0; c < 5; c++) begin
      next_cycle(); set_idle();
      #3;
      if (rv[0]) begin
        if (exp_q0.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rnd drain rsp0 unexpected: got %h, expected no response", rd[0]);
        end else check("rnd drain rsp0_rdata", rd[0], exp_q0.pop_front());
      end
      if (rv[1]) begin
        if (exp_q1.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rnd drain rsp1 unexpected: got %h, expected no response", rd[1]);
        end else check("rnd drain rsp1_rdata", rd[1], exp_q1.pop_front());
      end
    end
    check("rnd lost rsp0", exp_q0.size(), 0);
    check("rnd lost rsp1", exp_q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
